// File: rtl/vg_chk_pkg.sv
// Shared types and the expected-result function for the vector-gates result checker.
package vg_chk_pkg;

  localparam int VG_W = 3;

  // Bit positions inside the 3-bit field mismatch vector.
  localparam int FLD_BW  = 2;
  localparam int FLD_LG  = 1;
  localparam int FLD_NOT = 0;

  typedef struct packed {
    logic [VG_W-1:0]   a;
    logic [VG_W-1:0]   b;
    logic [VG_W-1:0]   dut_or_bitwise;
    logic              dut_or_logical;
    logic [2*VG_W-1:0] dut_not;
  } vg_sample_t;

  typedef struct packed {
    logic [VG_W-1:0]   or_bitwise;
    logic              or_logical;
    logic [2*VG_W-1:0] not_v;
  } vg_exp_t;

  function automatic vg_exp_t vg_expected(input logic [VG_W-1:0] a, input logic [VG_W-1:0] b);
    vg_exp_t r;
    r.or_bitwise = a | b;
    r.or_logical = (a != '0) || (b != '0);
    r.not_v      = {~b, ~a};
    return r;
  endfunction

endpackage

// File: rtl/vg_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module vg_chk_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vg_result_checker.sv
// Two-stage scoreboard for the vector-gates block: registers operands/observations,
// compares against recomputed results and keeps saturating counters plus a first-error record.
// Optional macro VG_CHK_SNAPSHOT_EN adds snap_a/snap_b/snap_dut captured with the first error.
module vg_result_checker
  import vg_chk_pkg::*;
#(
  parameter int W     = VG_W,
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     dut_or_bitwise,
  input  logic             dut_or_logical,
  input  logic [2*W-1:0]   dut_not,
  input  logic             clear,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] err_total,
  output logic [CNT_W-1:0] err_bitwise,
  output logic [CNT_W-1:0] err_logical,
  output logic [CNT_W-1:0] err_not,
  output logic             mismatch,
  output logic             first_err_valid,
  output logic [TS_W-1:0]  first_err_cycle,
  output logic [2:0]       first_err_fields
`ifdef VG_CHK_SNAPSHOT_EN
  ,
  output logic [W-1:0]     snap_a,
  output logic [W-1:0]     snap_b,
  output logic [3*W:0]     snap_dut
`endif
);

  logic [TS_W-1:0]  ts_reg;
  logic             s1_valid_reg;
  vg_sample_t       s1_reg;
  vg_exp_t          exp_reg;
  logic [2:0]       mis_vec;
  logic             fail;
  logic [4:0]       inc_vec;
  logic [CNT_W-1:0] cnt_arr [5];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ts_reg <= '0;
    end else begin
      ts_reg <= ts_reg + 1'b1;
    end
  end

  // Stage 1: capture the sample and its expected results; data holds when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_reg <= 1'b0;
      s1_reg       <= '0;
      exp_reg      <= '0;
    end else begin
      s1_valid_reg <= in_valid & ~clear;
      if (in_valid) begin
        s1_reg  <= '{a: a, b: b, dut_or_bitwise: dut_or_bitwise,
                     dut_or_logical: dut_or_logical, dut_not: dut_not};
        exp_reg <= vg_expected(a, b);
      end
    end
  end

  assign mis_vec[FLD_BW]  = s1_reg.dut_or_bitwise != exp_reg.or_bitwise;
  assign mis_vec[FLD_LG]  = s1_reg.dut_or_logical != exp_reg.or_logical;
  assign mis_vec[FLD_NOT] = s1_reg.dut_not        != exp_reg.not_v;
  assign fail             = s1_valid_reg && (mis_vec != 3'b000);

  // Counter order: samples, err_total, err_bitwise, err_logical, err_not.
  assign inc_vec = {s1_valid_reg, fail, fail & mis_vec[FLD_BW],
                    fail & mis_vec[FLD_LG], fail & mis_vec[FLD_NOT]};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_cnt
      vg_chk_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (inc_vec[4-gi]),
        .clr    (clear),
        .cnt    (cnt_arr[gi])
      );
    end
  endgenerate

  assign samples     = cnt_arr[0];
  assign err_total   = cnt_arr[1];
  assign err_bitwise = cnt_arr[2];
  assign err_logical = cnt_arr[3];
  assign err_not     = cnt_arr[4];

  // Stage 2: the recorded timestamp is the one visible while the counters show this sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mismatch         <= 1'b0;
      first_err_valid  <= 1'b0;
      first_err_cycle  <= '0;
      first_err_fields <= '0;
    end else if (clear) begin
      mismatch         <= 1'b0;
      first_err_valid  <= 1'b0;
      first_err_cycle  <= '0;
      first_err_fields <= '0;
    end else begin
      mismatch <= fail;
      if (fail && !first_err_valid) begin
        first_err_valid  <= 1'b1;
        first_err_cycle  <= ts_reg + 1'b1;
        first_err_fields <= mis_vec;
      end
    end
  end

`ifdef VG_CHK_SNAPSHOT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      snap_a   <= '0;
      snap_b   <= '0;
      snap_dut <= '0;
    end else if (clear) begin
      snap_a   <= '0;
      snap_b   <= '0;
      snap_dut <= '0;
    end else if (fail && !first_err_valid) begin
      snap_a   <= s1_reg.a;
      snap_b   <= s1_reg.b;
      snap_dut <= {s1_reg.dut_or_bitwise, s1_reg.dut_or_logical, s1_reg.dut_not};
    end
  end
`endif

endmodule

// File: tb/tb_vg_result_checker.sv
// Randomized and directed bench for vg_result_checker (CNT_W=16 and CNT_W=4 instances).
module tb_vg_result_checker;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] a = '0, b = '0, dut_or_bitwise = '0;
  logic       dut_or_logical = 1'b0;
  logic [5:0] dut_not = '0;
  logic       clear = 1'b0;

  logic [15:0] samples, err_total, err_bitwise, err_logical, err_not;
  logic        mismatch, first_err_valid;
  logic [31:0] first_err_cycle;
  logic [2:0]  first_err_fields;

  logic [3:0]  s4_samples, s4_err_total, s4_err_bitwise, s4_err_logical, s4_err_not;
  logic        s4_mismatch, s4_first_err_valid;
  logic [31:0] s4_first_err_cycle;
  logic [2:0]  s4_first_err_fields;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vg_result_checker #(.W(3), .CNT_W(16), .TS_W(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .a(a), .b(b),
    .dut_or_bitwise(dut_or_bitwise), .dut_or_logical(dut_or_logical), .dut_not(dut_not),
    .clear(clear), .samples(samples), .err_total(err_total), .err_bitwise(err_bitwise),
    .err_logical(err_logical), .err_not(err_not), .mismatch(mismatch),
    .first_err_valid(first_err_valid), .first_err_cycle(first_err_cycle),
    .first_err_fields(first_err_fields)
  );

  vg_result_checker #(.W(3), .CNT_W(4), .TS_W(32)) dut4 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .a(a), .b(b),
    .dut_or_bitwise(dut_or_bitwise), .dut_or_logical(dut_or_logical), .dut_not(dut_not),
    .clear(clear), .samples(s4_samples), .err_total(s4_err_total), .err_bitwise(s4_err_bitwise),
    .err_logical(s4_err_logical), .err_not(s4_err_not), .mismatch(s4_mismatch),
    .first_err_valid(s4_first_err_valid), .first_err_cycle(s4_first_err_cycle),
    .first_err_fields(s4_first_err_fields)
  );

  // Reference model: a queue of samples waiting to mature, plus unbounded tallies.
  typedef struct {
    int         due;
    logic [2:0] vec;
  } pend_t;
  pend_t      q[$];
  int         cyc;
  int         m_samples, m_tot, m_bw, m_lg, m_not;
  logic       m_mis, m_fev;
  int         m_fec;
  logic [2:0] m_fef;

  function automatic logic [2:0] fields_of(input logic [2:0] av, input logic [2:0] bv,
                                            input logic [2:0] bwv, input logic lgv,
                                            input logic [5:0] ntv);
    int sum_bits;
    int inv;
    logic [2:0] ebw;
    for (int i = 0; i < 3; i++) ebw[i] = av[i] | bv[i];
    sum_bits = int'(av) + int'(bv);
    inv = 63 - (int'(bv) * 8 + int'(av));
    return {bwv != ebw, lgv != (sum_bits != 0), int'(ntv) != inv};
  endfunction

  function automatic int sat(input int raw, input int maxv);
    return (raw > maxv) ? maxv : raw;
  endfunction

  task automatic model_zero();
    q.delete();
    m_samples = 0; m_tot = 0; m_bw = 0; m_lg = 0; m_not = 0;
    m_mis = 1'b0; m_fev = 1'b0; m_fec = 0; m_fef = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, " samples"},     32'(samples),     32'(sat(m_samples, 65535)));
    chk({ctx, " err_total"},   32'(err_total),   32'(sat(m_tot, 65535)));
    chk({ctx, " err_bitwise"}, 32'(err_bitwise), 32'(sat(m_bw, 65535)));
    chk({ctx, " err_logical"}, 32'(err_logical), 32'(sat(m_lg, 65535)));
    chk({ctx, " err_not"},     32'(err_not),     32'(sat(m_not, 65535)));
    chk({ctx, " fev"},         32'(first_err_valid),  32'(m_fev));
    chk({ctx, " fec"},         first_err_cycle,       32'(m_fec));
    chk({ctx, " fef"},         32'(first_err_fields), 32'(m_fef));
    chk({ctx, " s4 samples"},  32'(s4_samples),     32'(sat(m_samples, 15)));
    chk({ctx, " s4 err_total"},32'(s4_err_total),   32'(sat(m_tot, 15)));
    chk({ctx, " s4 err_bw"},   32'(s4_err_bitwise), 32'(sat(m_bw, 15)));
    chk({ctx, " s4 err_lg"},   32'(s4_err_logical), 32'(sat(m_lg, 15)));
    chk({ctx, " s4 err_not"},  32'(s4_err_not),     32'(sat(m_not, 15)));
    chk({ctx, " s4 fev"},      32'(s4_first_err_valid), 32'(m_fev));
    chk({ctx, " mismatch"},    32'(mismatch),    32'(m_mis));
    chk({ctx, " s4 mismatch"}, 32'(s4_mismatch), 32'(m_mis));
  endtask

  // One clock cycle: drive, take the edge, advance the model, check the pulse.
  task automatic cycle(input logic iv, input logic [2:0] av, input logic [2:0] bv,
                       input logic [2:0] bwv, input logic lgv, input logic [5:0] ntv,
                       input logic clr);
    pend_t p;
    in_valid = iv; a = av; b = bv; dut_or_bitwise = bwv; dut_or_logical = lgv;
    dut_not = ntv; clear = clr;
    @(posedge clk);
    #1;
    cyc++;
    m_mis = 1'b0;
    if (clr) begin
      model_zero();
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        p = q.pop_front();
        m_samples++;
        if (p.vec != 3'b000) begin
          m_tot++;
          m_mis = 1'b1;
          if (p.vec[2]) m_bw++;
          if (p.vec[1]) m_lg++;
          if (p.vec[0]) m_not++;
          if (!m_fev) begin
            m_fev = 1'b1; m_fec = cyc; m_fef = p.vec;
          end
        end
      end
      if (iv) q.push_back('{due: cyc + 1, vec: fields_of(av, bv, bwv, lgv, ntv)});
    end
    $display("cyc=%0d iv=%0b a=%0d b=%0d bw=%0d lg=%0b nt=%02h clr=%0b -> samples=%0d err=%0d mis=%0b",
             cyc, iv, av, bv, bwv, lgv, ntv, clr, samples, err_total, mismatch);
    chk("mismatch pulse", 32'(mismatch), 32'(m_mis));
    chk("s4 mismatch pulse", 32'(s4_mismatch), 32'(m_mis));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic good(input logic [2:0] av, input logic [2:0] bv);
    logic [5:0] ab;
    ab = {bv, av};
    cycle(1'b1, av, bv, av | bv, (av != 0) || (bv != 0), ~ab, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    in_valid = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc = 0;
    model_zero();
  endtask

  initial begin
    logic [5:0] v;
    logic [2:0] ra, rb, rbw;
    logic       rlg;
    logic [5:0] rnt, rab;

    // Reset state
    #1;
    do_reset();
    check_all("reset");

    // 30 correct samples from {b,a}=6'h38 with wrap
    for (int i = 0; i < 30; i++) begin
      v = 6'(8'h38 + i);
      good(v[2:0], v[5:3]);
    end
    idle(2);
    check_all("clean30");
    chk("clean30 samples=30", 32'(samples), 32'd30);

    // Logical-field error at timestamp 10
    do_reset();
    idle(10);
    cycle(1'b1, 3'b000, 3'b000, 3'b000, 1'b1, 6'b111111, 1'b0);
    idle(2);
    check_all("logical");
    chk("logical fec=12", first_err_cycle, 32'd12);
    chk("logical fef=010", 32'(first_err_fields), 32'b010);

    // Bitwise+not error, then a second failure leaves the record intact
    do_reset();
    cycle(1'b1, 3'b101, 3'b010, 3'b110, 1'b1, 6'b000000, 1'b0);
    idle(2);
    check_all("bw_not");
    chk("bw_not fef=101", 32'(first_err_fields), 32'b101);
    cycle(1'b1, 3'b000, 3'b000, 3'b000, 1'b1, 6'b111111, 1'b0);
    idle(2);
    check_all("second_err");

    // 20 consecutive bitwise failures: 4-bit instance saturates at 15
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 3'b001, 3'b000, 3'b000, 1'b1, 6'b111110, 1'b0);
    idle(2);
    check_all("saturate");
    chk("s4 err_bitwise=15", 32'(s4_err_bitwise), 32'd15);
    chk("s4 samples=15", 32'(s4_samples), 32'd15);

    // Failing sample followed by clear, and in_valid coincident with clear
    do_reset();
    cycle(1'b1, 3'b011, 3'b000, 3'b000, 1'b1, 6'b111100, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    cycle(1'b1, 3'b011, 3'b000, 3'b000, 1'b1, 6'b111100, 1'b1);
    idle(3);
    check_all("clear_drop");

    // Randomized traffic with occasional clears
    for (int i = 0; i < 300; i++) begin
      ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7));
      rab = {rb, ra};
      rbw = ra | rb;
      rlg = (ra != 0) || (rb != 0);
      rnt = ~rab;
      if ($urandom_range(0, 3) == 0) rbw ^= 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) rlg = ~rlg;
      if ($urandom_range(0, 4) == 0) rnt ^= 6'($urandom_range(0, 63));
      cycle(($urandom_range(0, 3) != 0), ra, rb, rbw, rlg, rnt, ($urandom_range(0, 60) == 0));
      check_all("rand");
    end

    // Guarantee nonzero counters, then assert reset between edges
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'b010, 3'b001, 3'b000, 1'b0, 6'b000000, 1'b0);
    idle(2);
    check_all("pre_async");
    #3;
    resetn = 1'b0;
    #1;
    model_zero();
    check_all("async_reset");
    do_reset();
    good(3'b100, 3'b001);
    idle(2);
    check_all("after_reset");
    chk("after_reset samples=1", 32'(samples), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vg_result_checker.md
Name: vg_result_checker

Overview:
- Synthesizable scoreboard that sits directly downstream of the vector-gates block.
- Consumes the operands {b,a} and the block's three outputs, recomputes the expected results internally, and compares field by field.
- Maintains saturating sample and mismatch counters per output field, and records the cycle of the first mismatch.
- Used in on-chip bring-up and as a bench-side checker in place of behavioural comparison.

Parameters:
W, 3, operand width of a and b.
CNT_W, 16, width of the sample and error counters.
TS_W, 32, width of the free-running cycle timestamp.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
resetn  input  1  asynchronous, active-low reset.
in_valid  input  1  current a/b/dut_* form one sample to be checked.
a  input  W  operand a as driven to the checked block.
b  input  W  operand b as driven to the checked block.
dut_or_bitwise  input  W  observed bitwise-OR output.
dut_or_logical  input  1  observed logical-OR output.
dut_not  input  2W  observed inverted output.
clear  input  1  synchronous clear of counters and first-error record.
samples  output  CNT_W  number of checked samples (saturating).
err_total  output  CNT_W  samples with at least one mismatching field (saturating).
err_bitwise  output  CNT_W  mismatches on or_bitwise.
err_logical  output  CNT_W  mismatches on or_logical.
err_not  output  CNT_W  mismatches on not.
mismatch  output  1  one-cycle registered pulse for a failing sample.
first_err_valid  output  1  sticky; a first error has been recorded.
first_err_cycle  output  TS_W  timestamp of the first failing sample.
first_err_fields  output  3  fields that failed in the first error; bit2=bitwise, bit1=logical, bit0=not.

Behaviour:
- Reset (resetn=0, asynchronous): all outputs, counters, the timestamp and pipeline valid bits are set to 0.
- Timestamp: TS_W-bit counter, +1 every cycle after reset release, wraps from all-ones to 0. It is not affected by clear.
- Stage 1, cycle after in_valid=1:
  - Registers a, b and all dut_* inputs.
  - Computes expected values: exp_bw = a|b; exp_lg = (a!=0)||(b!=0); exp_not = {~b,~a}.
  - When in_valid=0, the stage-1 valid bit is 0 and its data registers hold.
- Stage 2, two cycles after in_valid=1:
  - Computes the 3-bit field mismatch vector; samples += 1.
  - If the vector is nonzero: err_total += 1, each failing field's counter += 1, and mismatch=1 for exactly that cycle.
- Latency: counters and mismatch reflect a sample exactly 2 cycles after its in_valid. Back-to-back in_valid is accepted every cycle; there is no backpressure.
- Saturation: every counter holds at 2^CNT_W-1 and never wraps. Saturation of one counter does not affect the others.
- First error: on the first nonzero mismatch vector while first_err_valid=0:
  - first_err_cycle is set to the stage-2 timestamp value.
  - first_err_fields is set to the mismatch vector.
  - first_err_valid is set to 1.
  - These fields hold until clear or reset.
- clear=1:
  - Next edge zeroes all counters, mismatch, first_err_* and both pipeline valid bits.
  - In-flight samples are dropped and never counted.
  - clear wins over a simultaneous stage-2 update.
  - in_valid in the same cycle as clear is also dropped.
- Reset asserted mid-stream: immediate return to the reset state. Nothing is counted until in_valid is seen after release.

Optional Feature:
- Macro: VG_CHK_SNAPSHOT_EN.
- Defined: adds outputs snap_a (W), snap_b (W) and snap_dut (3W+1 = {or_bitwise, or_logical, not}). These capture the stage-2 operands and observed outputs at the same edge that sets first_err_valid, and hold under the same rules as first_err_*.
- Undefined: these ports and registers do not exist. Core behaviour is identical.

Decomposition:
- Package vg_chk_pkg:
  - Field index constants FLD_BW=2, FLD_LG=1, FLD_NOT=0.
  - Packed typedef vg_sample_t {a, b, dut_or_bitwise, dut_or_logical, dut_not} parameterized on W through the localparam VG_W=3.
  - Function vg_expected() returning the expected triple.
- Sub-module vg_chk_sat_cnt: CNT_W saturating counter with inputs inc and clr. Instantiated five times.

Test Plan:
- Reset then 30 correct samples, {b,a} = 6'h38 incrementing with wrap → 2 cycles after the last one: samples=30, err_total=0, first_err_valid=0, mismatch never 1.
- a=3'b000, b=3'b000, dut_or_logical=1, other fields correct, at timestamp 10 → mismatch pulse 2 cycles later; err_logical=1, err_total=1, first_err_fields=3'b010, first_err_cycle=12.
- a=3'b101, b=3'b010, dut_or_bitwise=3'b110, dut_not=6'b000000 → err_bitwise=1, err_not=1, err_total=1. A second failing sample leaves first_err_* unchanged.
- CNT_W=4, 20 consecutive failing samples on or_bitwise → err_bitwise and err_total hold at 15; samples reaches 15 and holds.
- Failing sample with in_valid at cycle N and clear at cycle N+1 → the sample is not counted: all counters 0, first_err_valid=0, no mismatch pulse.
- resetn driven low asynchronously between edges while counters are nonzero → all outputs 0 immediately, without waiting for a clk edge. After release, one correct sample gives samples=1.
